// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the mm:ss timers: FSM encodings, the default
// prescaler length and the mm:ss field limit with its clamp helper.
package countdown_timer_pkg;

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_COUNT = 2'b11;
   localparam logic [1:0] ST_PAUSE = 2'b01;
   localparam logic [1:0] ST_DONE  = 2'b10;

   localparam int DEFAULT_TICKS_PER_SEC = 65_000_000;

   localparam logic [5:0] MAX_MM_SS = 6'd59;

   // Clamp a 6-bit minutes or seconds field into the displayable 0..59 range.
   function automatic logic [5:0] clamp_mm_ss(input logic [5:0] value);
      return (value > MAX_MM_SS) ? MAX_MM_SS : value;
   endfunction

endpackage

// File: rtl/countdown_timer_tick_gen.sv
// One-second prescaler. The counter advances only while enabled, so a
// paused timer resumes part-way through the second it was frozen in.
module sec_tick_gen
   import countdown_timer_pkg::*;
#(
   parameter int TICKS_PER_SEC = DEFAULT_TICKS_PER_SEC
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CTR_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [CTR_W-1:0] TERM = CTR_W'(TICKS_PER_SEC - 1);

   logic [CTR_W-1:0] ctr;

   // Clear has priority over counting; the count wraps at the terminal value.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         ctr <= '0;
      end else if (en) begin
         ctr <= (ctr == TERM) ? '0 : ctr + 1'b1;
      end
   end

   assign tick = (ctr == TERM);

endmodule

// File: rtl/countdown_timer.sv
// Down-counting mm:ss timer for the Memory Game. Game control loads a
// budget, then starts, pauses, resumes or stops it; expiry is reported by a
// one-cycle pulse and a low-time warning level accompanies the last seconds.
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int TICKS_PER_SEC = DEFAULT_TICKS_PER_SEC,
   parameter int WARN_SECONDS  = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [5:0] load_minutes,
   input  logic [5:0] load_seconds,
   input  logic       start,
   input  logic       pause,
   input  logic       stop,
   output logic [5:0] minutes,
   output logic [5:0] seconds,
   output logic       running,
   output logic       paused,
   output logic       warning,
   output logic       expired
);

   localparam logic [5:0] WARN_LIMIT = 6'(WARN_SECONDS);

   logic [1:0] state;
   logic [1:0] state_n;
   logic [5:0] minutes_n;
   logic [5:0] seconds_n;
   logic [5:0] reload_min;
   logic [5:0] reload_sec;
   logic [5:0] reload_min_n;
   logic [5:0] reload_sec_n;
   logic       expired_n;
   logic       warning_n;
   logic       time_zero;
   logic       tick;
   logic       tick_en;
   logic       tick_clr;

   sec_tick_gen #(
      .TICKS_PER_SEC(TICKS_PER_SEC)
   ) u_tick (
      .clk (clk),
      .rst (rst),
      .en  (tick_en),
      .clr (tick_clr),
      .tick(tick)
   );

   assign time_zero = (minutes == 6'd0) && (seconds == 6'd0);

   // Next-state, next-time and prescaler control for every state and command.
   always_comb begin
      state_n      = state;
      minutes_n    = minutes;
      seconds_n    = seconds;
      reload_min_n = reload_min;
      reload_sec_n = reload_sec;
      expired_n    = 1'b0;
      tick_en      = 1'b0;
      tick_clr     = 1'b0;

      case (state)
         ST_IDLE: begin
            if (load) begin
               reload_min_n = clamp_mm_ss(load_minutes);
               reload_sec_n = clamp_mm_ss(load_seconds);
               minutes_n    = clamp_mm_ss(load_minutes);
               seconds_n    = clamp_mm_ss(load_seconds);
            end else if (start && !time_zero) begin
               state_n  = ST_COUNT;
               tick_clr = 1'b1;
            end
         end

         ST_COUNT: begin
            if (stop) begin
               state_n   = ST_IDLE;
               minutes_n = reload_min;
               seconds_n = reload_sec;
               tick_clr  = 1'b1;
            end else if (pause) begin
               state_n = ST_PAUSE;
            end else begin
               tick_en = 1'b1;
               if (tick) begin
                  if (seconds != 6'd0) begin
                     seconds_n = seconds - 6'd1;
                  end else if (minutes != 6'd0) begin
                     seconds_n = MAX_MM_SS;
                     minutes_n = minutes - 6'd1;
                  end
                  if ((minutes_n == 6'd0) && (seconds_n == 6'd0)) begin
                     state_n   = ST_DONE;
                     expired_n = 1'b1;
                  end
               end
            end
         end

         ST_PAUSE: begin
            if (stop) begin
               state_n   = ST_IDLE;
               minutes_n = reload_min;
               seconds_n = reload_sec;
               tick_clr  = 1'b1;
            end else if (start) begin
               state_n = ST_COUNT;
            end
         end

         ST_DONE: begin
            minutes_n = 6'd0;
            seconds_n = 6'd0;
            if (stop) begin
               state_n   = ST_IDLE;
               minutes_n = reload_min;
               seconds_n = reload_sec;
            end else if (load) begin
               state_n      = ST_IDLE;
               reload_min_n = clamp_mm_ss(load_minutes);
               reload_sec_n = clamp_mm_ss(load_seconds);
               minutes_n    = clamp_mm_ss(load_minutes);
               seconds_n    = clamp_mm_ss(load_seconds);
            end
         end

         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   // Warning is derived from the next time so it lands on the same edge as the display.
   always_comb begin
      warning_n = ((state_n == ST_COUNT) || (state_n == ST_PAUSE)) &&
                  (minutes_n == 6'd0) && (seconds_n != 6'd0) &&
                  (seconds_n <= WARN_LIMIT);
   end

   // Register the state, time, reload value and all status flags together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         minutes    <= 6'd0;
         seconds    <= 6'd0;
         reload_min <= 6'd0;
         reload_sec <= 6'd0;
         running    <= 1'b0;
         paused     <= 1'b0;
         warning    <= 1'b0;
         expired    <= 1'b0;
      end else begin
         state      <= state_n;
         minutes    <= minutes_n;
         seconds    <= seconds_n;
         reload_min <= reload_min_n;
         reload_sec <= reload_sec_n;
         running    <= (state_n == ST_COUNT);
         paused     <= (state_n == ST_PAUSE);
         warning    <= warning_n;
         expired    <= expired_n;
      end
   end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Down-counting mm:ss timer for the Memory Game; the inverse of the elapsed-time stopwatch.
- Game control loads a time budget, then starts, pauses, resumes and stops it.
- The block counts down once per second and reports expiry with a one-cycle pulse plus a low-time warning level.
- Outputs drive the same mm:ss display path as the stopwatch.

Parameters:
- TICKS_PER_SEC, 65_000_000: clk cycles per counted second; prescaler terminal count is TICKS_PER_SEC-1.
- WARN_SECONDS, 10: warning asserts when remaining time is 00:01..00:WARN_SECONDS; legal range 0..59.

Ports:
- clk  in  1  system clock (65 MHz)
- rst  in  1  synchronous, active-high reset
- load  in  1  latch load_minutes/load_seconds; honoured only in IDLE or DONE
- load_minutes  in  6  time budget minutes
- load_seconds  in  6  time budget seconds
- start  in  1  begin counting from IDLE, or resume from PAUSE
- pause  in  1  freeze the count (COUNT only)
- stop  in  1  abort and restore the loaded budget
- minutes  out  6  remaining minutes, 0..59
- seconds  out  6  remaining seconds, 0..59
- running  out  1  high in COUNT
- paused  out  1  high in PAUSE
- warning  out  1  low-time level
- expired  out  1  single-cycle pulse on reaching 00:00

Behaviour:
- All outputs and registers are registered and updated on posedge clk.
- rst overrides every other input in any state: state=IDLE, minutes=seconds=0, reload=0, ctr=0, all flags 0.
- Reload register: holds the last accepted load value, with each field clamped to 59 (a value >59 becomes 59).
- States (2-bit): IDLE, COUNT, PAUSE, DONE.
- IDLE:
  - load: reload and minutes/seconds take the clamped inputs next cycle.
  - start with time != 00:00: go to COUNT, ctr=0.
  - start with time == 00:00: ignored.
  - load and start in the same cycle: load is taken, start is ignored.
- COUNT, priority stop > pause > tick:
  - stop: go to IDLE, minutes/seconds = reload, ctr=0.
  - pause: go to PAUSE, ctr held, no decrement this cycle.
  - Otherwise ctr increments. At ctr==TICKS_PER_SEC-1: ctr=0 and the time decrements.
    - seconds>0: seconds-1.
    - seconds==0: seconds=59 and minutes-1.
  - If a decrement yields 00:00: state=DONE and expired=1 in that same cycle, for exactly one cycle.
  - load and start are ignored.
- PAUSE, priority stop > start:
  - stop: go to IDLE with reload restored.
  - start: go to COUNT with ctr resumed from its held value.
  - pause and load are ignored; ctr and the time are frozen.
- DONE: minutes=seconds=0, expired low after the first cycle.
  - stop: go to IDLE with reload restored.
  - load: go to IDLE with the new values.
  - stop and load together: stop wins.
  - start and pause are ignored.
- warning = (state is COUNT or PAUSE) and minutes==0 and 1 <= seconds <= WARN_SECONDS. It is computed from registered values (one cycle after the time changes is not acceptable); register it alongside the time.
- running = (state==COUNT); paused = (state==PAUSE); both registered with the state.
- No wrap-around: the count saturates at 00:00 in DONE. Minutes never underflow.
- Width rules: ctr is $clog2(TICKS_PER_SEC) bits; time fields are 6-bit unsigned.

Decomposition:
- Shared header timer_defs.vh holds:
  - state encodings IDLE=2'b00, COUNT=2'b11, PAUSE=2'b01, DONE=2'b10;
  - the default TICKS_PER_SEC;
  - MAX_MM_SS=59.
- The stopwatch and countdown_timer share this header.
- Sub-module sec_tick_gen (params TICKS_PER_SEC; ports clk, rst, en, clr, tick):
  - ctr counts while en, holds while !en, zeroes on clr;
  - tick pulses when ctr==TICKS_PER_SEC-1.
  - countdown_timer drives en=(next state stays COUNT, no pause/stop) and clr on start-from-IDLE/stop.

Test Plan:
- TICKS_PER_SEC=4, WARN_SECONDS=2. Reset, load 00:03, start → seconds 3→2→1→0 every 4 cycles; expired high exactly one cycle when 00:00 appears; state DONE; warning high at 00:02 and 00:01, low at 00:00.
- Load 01:00, start, wait one tick → 00:59; minutes borrow correct, no underflow.
- Load 00:05, start, pause at ctr=2 for 10 cycles → time frozen at 00:05, paused=1. Start → next decrement occurs after 2 more cycles (ctr resumed).
- Load 02:30, start, after 3 ticks assert stop and pause together → IDLE (stop wins), display 02:30, running=paused=0.
- Load 63:63 → display 59:59. Load 00:00 then start → remains IDLE, no expired.
- Mid-count rst with start held → all outputs 0, IDLE, reload 0; start after reset release is ignored since the time is 00:00.
